// File: rtl/conv_encoder_param_pkg.sv
// rtl/conv_encoder_param_pkg.sv - shared types, default polynomials and parity helper for conv_encoder_param
package conv_enc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_META,
        ST_LOAD,
        ST_PRIME,
        ST_ENCODE,
        ST_DONE
    } enc_state_e;

    localparam int K_DEF     = 7;
    localparam int N_OUT_DEF = 3;

    // LTE generators, stream 0 in the most significant K bits
    localparam logic [N_OUT_DEF*K_DEF-1:0] GEN_LTE = {7'o133, 7'o171, 7'o165};

    function automatic logic parity(input logic [31:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/conv_encoder_param_if.sv
// rtl/conv_encoder_param_if.sv - FIFO, block-control and coded-output bundle; term_mode exists only with CONV_ENC_TERM_EN
interface conv_encoder_param_if #(
    parameter int N_OUT = 3,
    parameter int LEN_W = 10
);
    logic               blk_ready;
    logic [LEN_W-1:0]   blk_meta;
    logic               blk_meta_empty;
    logic               blk_meta_rdreq;
    logic [7:0]         blk_data;
    logic               blk_data_empty;
    logic               blk_data_rdreq;
    logic               out_ready;
    logic [N_OUT-1:0]   d_out;
    logic               d_valid;
    logic [LEN_W+2:0]   bit_cnt;
    logic               computation_done;
    logic               busy;
    logic               err;
`ifdef CONV_ENC_TERM_EN
    logic               term_mode;
`endif

    modport master (
        input  blk_ready, blk_meta, blk_meta_empty, blk_data, blk_data_empty, out_ready,
`ifdef CONV_ENC_TERM_EN
        input  term_mode,
`endif
        output blk_meta_rdreq, blk_data_rdreq, d_out, d_valid, bit_cnt,
        output computation_done, busy, err
    );

    modport slave (
        output blk_ready, blk_meta, blk_meta_empty, blk_data, blk_data_empty, out_ready,
`ifdef CONV_ENC_TERM_EN
        output term_mode,
`endif
        input  blk_meta_rdreq, blk_data_rdreq, d_out, d_valid, bit_cnt,
        input  computation_done, busy, err
    );

endinterface

// File: rtl/conv_encoder_param_blk_ram.sv
// rtl/conv_encoder_param_blk_ram.sv - 8-bit simple dual-port block buffer with registered 1-cycle read
module conv_enc_blk_ram #(
    parameter int DEPTH = 768,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    // Read data holds while rd_en_i is low, so the encoder can use it as its current byte
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/conv_encoder_param.sv
// rtl/conv_encoder_param.sv - rate-1/N tail-biting convolutional encoder; CONV_ENC_TERM_EN adds zero-tail termination via term_mode
module conv_encoder_param
    import conv_enc_pkg::*;
#(
    parameter int                   K         = K_DEF,
    parameter int                   N_OUT     = N_OUT_DEF,
    parameter logic [N_OUT*K-1:0]   GEN       = GEN_LTE,
    parameter int                   MAX_BYTES = 768,
    parameter int                   LEN_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    conv_encoder_param_if.master bus
);

    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam int CW = LEN_W + 3;
    localparam logic [LEN_W:0]   MAX_L = (LEN_W+1)'(MAX_BYTES);
    localparam logic [LEN_W-1:0] ONE_L = 1;
    localparam logic [CW-1:0]    ONE_C = 1;

    enc_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] addr_q, addr_d;
    logic             prime_q, prime_d;
    logic [K-2:0]     s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             term_q, term_d;

    logic             meta_rdreq, data_rdreq, err_w, done_w, valid;
    logic             rd_en;
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data;
    logic [LEN_W-1:0] len_m1, next_byte;
    logic [CW-1:0]    total_bits;
    logic [2:0]       bit_idx;
    logic             u;
    logic [K-1:0]     r;
    logic [N_OUT-1:0] d_out_w;
    logic             term_in;

`ifdef CONV_ENC_TERM_EN
    assign term_in = bus.term_mode;
`else
    assign term_in = 1'b0;
`endif

    conv_enc_blk_ram #(.DEPTH(MAX_BYTES), .AW(AW)) u_ram (
        .clk       (clk),
        .wr_en_i   (data_rdreq),
        .wr_addr_i (addr_q[AW-1:0]),
        .wr_data_i (bus.blk_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    assign len_m1     = len_q - ONE_L;
    assign next_byte  = cnt_q[CW-1:3] + ONE_L;
    assign total_bits = {len_q, 3'b000} + (term_q ? CW'(K-1) : '0);
    assign bit_idx    = cnt_q[2:0];
    // Bits beyond 8L only occur in zero-tail mode and are fed as zeros
    assign u          = (cnt_q < {len_q, 3'b000}) & rd_data[3'd7 - bit_idx];

    // s_q[0] is the most recent bit; the tap next to u must see it
    always_comb begin
        r      = '0;
        r[K-1] = u;
        for (int i = 0; i < K-1; i++) r[K-2-i] = s_q[i];
    end

    always_comb begin
        d_out_w = '0;
        for (int j = 0; j < N_OUT; j++)
            d_out_w[j] = valid & parity(32'(r & GEN[(N_OUT-1-j)*K +: K]));
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        prime_d    = prime_q;
        s_d        = s_q;
        cnt_d      = cnt_q;
        term_d     = term_q;
        meta_rdreq = 1'b0;
        data_rdreq = 1'b0;
        err_w      = 1'b0;
        done_w     = 1'b0;
        valid      = 1'b0;
        rd_en      = 1'b0;
        rd_addr    = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.blk_ready && !bus.blk_meta_empty) state_d = ST_META;
            end
            ST_META: begin
                if (!bus.blk_meta_empty) begin
                    meta_rdreq = 1'b1;
                    len_d      = bus.blk_meta;
                    addr_d     = '0;
                    cnt_d      = '0;
                    prime_d    = 1'b0;
                    term_d     = term_in;
                    if (bus.blk_meta == '0 || {1'b0, bus.blk_meta} > MAX_L) begin
                        err_w   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (!bus.blk_data_empty) begin
                    data_rdreq = 1'b1;
                    addr_d     = addr_q + ONE_L;
                    if (addr_q == len_m1) state_d = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (!prime_q) begin
                    rd_en   = !term_q;
                    rd_addr = len_m1[AW-1:0];
                    prime_d = 1'b1;
                end else begin
                    rd_en   = 1'b1;
                    rd_addr = '0;
                    s_d     = term_q ? '0 : rd_data[K-2:0];
                    state_d = ST_ENCODE;
                end
            end
            ST_ENCODE: begin
                valid = 1'b1;
                if (bus.out_ready) begin
                    s_d   = {s_q[K-3:0], u};
                    cnt_d = cnt_q + ONE_C;
                    // Fetch the next byte while its predecessor's last bit is taken
                    if (bit_idx == 3'd7 && next_byte < len_q) begin
                        rd_en   = 1'b1;
                        rd_addr = next_byte[AW-1:0];
                    end
                    if (cnt_q == total_bits - ONE_C) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_w  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            addr_q  <= '0;
            prime_q <= 1'b0;
            s_q     <= '0;
            cnt_q   <= '0;
            term_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            prime_q <= prime_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
        end
    end

    assign bus.blk_meta_rdreq   = meta_rdreq;
    assign bus.blk_data_rdreq   = data_rdreq;
    assign bus.d_out            = d_out_w;
    assign bus.d_valid          = valid;
    assign bus.bit_cnt          = cnt_q;
    assign bus.computation_done = done_w;
    assign bus.busy             = (state_q != ST_IDLE);
    assign bus.err              = err_w;

endmodule

// File: tb/tb_conv_encoder_param.sv
// tb/tb_conv_encoder_param.sv - directed self-checking bench for conv_encoder_param (term test with CONV_ENC_TERM_EN)
module tb_conv_encoder_param;
    import conv_enc_pkg::*;

    localparam int K = 7;
    localparam int N_OUT = 3;
    localparam int LEN_W = 10;
    localparam int MAX_BYTES = 768;

    logic clk;
    logic reset;

    conv_encoder_param_if #(.N_OUT(N_OUT), .LEN_W(LEN_W)) bus ();

    conv_encoder_param #(
        .K(K), .N_OUT(N_OUT), .GEN(GEN_LTE), .MAX_BYTES(MAX_BYTES), .LEN_W(LEN_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    logic [LEN_W-1:0] meta_q[$];
    logic [7:0]       data_q[$];
    logic [7:0]       blk_bytes[$];
    logic [N_OUT-1:0] exp_q[$];
    logic [N_OUT-1:0] cap_q[$];
    logic [N_OUT-1:0] ref_q[$];

    bit pop_m = 0, pop_d = 0, stall_mode = 0;
    int pops, rd_when_empty, err_cnt, xfer_cnt, mism, valid_cyc;
    int done_cnt, done_cyc, last_xfer, first_valid, busy_start, max_bc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic bit in_bit(input int t, input int nbits, input bit term);
        int idx;
        logic [7:0] b;
        idx = t;
        if (idx < 0) begin
            if (term) return 1'b0;
            idx += nbits;
        end
        if (idx >= nbits) return 1'b0;
        b = blk_bytes[idx/8];
        return b[7 - (idx % 8)];
    endfunction

    // Reference: out_j(t) = XOR_i g_j[K-1-i] * x(t-i), x circular (tail-biting) or zero-padded
    task automatic build_exp(input int len, input bit term);
        logic [6:0] g [3];
        int nbits, nset;
        logic [N_OUT-1:0] s;
        g[0] = 7'o133; g[1] = 7'o171; g[2] = 7'o165;
        nbits = 8 * len;
        nset = nbits + (term ? K-1 : 0);
        exp_q.delete();
        for (int t = 0; t < nset; t++) begin
            s = '0;
            for (int j = 0; j < N_OUT; j++)
                for (int i = 0; i < K; i++)
                    if (g[j][K-1-i] && in_bit(t - i, nbits, term)) s[j] = ~s[j];
            exp_q.push_back(s);
        end
    endtask

    function automatic logic [15:0] stream_word(input int j);
        logic [15:0] w;
        logic [N_OUT-1:0] e;
        w = '0;
        for (int i = 0; i < cap_q.size(); i++) begin
            e = cap_q[i];
            w = {w[14:0], e[j]};
        end
        return w;
    endfunction

    // FIFO models: pops seen at the negedge take effect at the following posedge
    initial forever begin
        bit stall_e;
        logic [7:0] tmp_d;
        logic [LEN_W-1:0] tmp_m;
        @(posedge clk);
        #1;
        if (pop_m && meta_q.size() > 0) tmp_m = meta_q.pop_front();
        if (pop_d && data_q.size() > 0) tmp_d = data_q.pop_front();
        pop_m = 0;
        pop_d = 0;
        stall_e = stall_mode && ($urandom_range(0, 3) == 0);
        bus.blk_meta_empty = (meta_q.size() == 0);
        bus.blk_meta = (meta_q.size() > 0) ? meta_q[0] : '0;
        bus.blk_data_empty = (data_q.size() == 0) || stall_e;
        bus.blk_data = (data_q.size() > 0) ? data_q[0] : '0;
        bus.out_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    always @(negedge clk) if (!reset) begin
        if (bus.blk_meta_rdreq) pop_m = 1;
        if (bus.blk_data_rdreq) begin
            pop_d = 1;
            pops++;
            if (bus.blk_data_empty) rd_when_empty++;
        end
        if (bus.err) err_cnt++;
        if (bus.busy && busy_start < 0) busy_start = cyc;
        if (bus.d_valid) begin
            if (first_valid < 0) first_valid = cyc;
            valid_cyc++;
            if (int'(bus.bit_cnt) > max_bc) max_bc = int'(bus.bit_cnt);
            if (xfer_cnt >= exp_q.size()) mism++;
            else if (bus.d_out !== exp_q[xfer_cnt] || int'(bus.bit_cnt) != xfer_cnt) mism++;
            if (bus.out_ready) begin
                cap_q.push_back(bus.d_out);
                xfer_cnt++;
                last_xfer = cyc;
            end
        end
        if (bus.computation_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic start_block(input int len, input bit term);
        build_exp(len, term);
        pops = 0; rd_when_empty = 0; xfer_cnt = 0; mism = 0; valid_cyc = 0; max_bc = -1;
        done_cnt = 0; done_cyc = -1; last_xfer = -1; first_valid = -1; busy_start = -1;
        cap_q.delete();
        meta_q.push_back(LEN_W'(len));
        foreach (blk_bytes[i]) data_q.push_back(blk_bytes[i]);
`ifdef CONV_ENC_TERM_EN
        bus.term_mode = term;
`endif
        @(posedge clk);
        #2;
        bus.blk_ready = 1;
        for (int i = 0; i < 20 && !bus.busy; i++) @(negedge clk);
        bus.blk_ready = 0;
    endtask

    task automatic finish_block(input string tag, input int len, input bit stalled);
        for (int i = 0; i < 30000 && done_cnt == 0; i++) @(negedge clk);
        @(negedge clk);
        check_eq($sformatf("%s_done", tag), done_cnt, 1);
        check_eq($sformatf("%s_stream", tag), mism, 0);
        check_eq($sformatf("%s_sets", tag), xfer_cnt, exp_q.size());
        check_eq($sformatf("%s_pops", tag), pops, len);
        check_eq($sformatf("%s_rd_empty", tag), rd_when_empty, 0);
        check_eq($sformatf("%s_done_cyc", tag), done_cyc, last_xfer + 1);
        check_eq($sformatf("%s_max_bitcnt", tag), max_bc, exp_q.size() - 1);
        check_eq($sformatf("%s_busy_end", tag), bus.busy, 0);
        if (!stalled) begin
            check_eq($sformatf("%s_latency", tag), first_valid - busy_start, len + 3);
            check_eq($sformatf("%s_valid_run", tag), valid_cyc, exp_q.size());
        end
    endtask

    task automatic illegal(input int len, input string tag);
        int e0;
        e0 = err_cnt;
        meta_q.push_back(LEN_W'(len));
        @(posedge clk);
        #2;
        bus.blk_ready = 1;
        for (int i = 0; i < 10 && err_cnt == e0; i++) @(negedge clk);
        bus.blk_ready = 0;
        repeat (3) @(negedge clk);
        check_eq($sformatf("%s_err", tag), err_cnt - e0, 1);
        check_eq($sformatf("%s_busy", tag), bus.busy, 0);
        check_eq($sformatf("%s_meta_popped", tag), meta_q.size(), 0);
    endtask

    initial begin
        reset = 1;
        bus.blk_ready = 0;
        bus.blk_meta = '0;
        bus.blk_meta_empty = 1;
        bus.blk_data = '0;
        bus.blk_data_empty = 1;
        bus.out_ready = 1;
`ifdef CONV_ENC_TERM_EN
        bus.term_mode = 0;
`endif
        err_cnt = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_meta_rdreq", bus.blk_meta_rdreq, 0);
        check_eq("rst_data_rdreq", bus.blk_data_rdreq, 0);
        check_eq("rst_d_out", bus.d_out, 0);
        check_eq("rst_d_valid", bus.d_valid, 0);
        check_eq("rst_bit_cnt", bus.bit_cnt, 0);
        check_eq("rst_done", bus.computation_done, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_err", bus.err, 0);
        reset = 0;
        repeat (2) @(negedge clk);

        blk_bytes.delete(); blk_bytes.push_back(8'h80);
        start_block(1, 0);
        finish_block("impulse", 1, 0);
        check_eq("impulse_s0", stream_word(0), 16'h00B6);
        check_eq("impulse_s1", stream_word(1), 16'h00F2);
        check_eq("impulse_s2", stream_word(2), 16'h00EA);

        blk_bytes.delete(); blk_bytes.push_back(8'hFF);
        start_block(1, 0);
        finish_block("ones", 1, 0);
        check_eq("ones_s0", stream_word(0), 16'h00FF);
        check_eq("ones_s1", stream_word(1), 16'h00FF);
        check_eq("ones_s2", stream_word(2), 16'h00FF);

        blk_bytes.delete();
        for (int i = 0; i < 768; i++) blk_bytes.push_back(8'($urandom_range(0, 255)));
        start_block(768, 0);
        finish_block("tailbite768", 768, 0);

        pops = 0;
        illegal(0, "len0");
        illegal(769, "len769");
        check_eq("illegal_err_total", err_cnt, 2);
        check_eq("illegal_no_data_pop", pops, 0);

        blk_bytes.delete();
        for (int i = 0; i < 40; i++) blk_bytes.push_back(8'($urandom_range(0, 255)));
        start_block(40, 0);
        finish_block("l40_clean", 40, 0);
        ref_q = cap_q;
        stall_mode = 1;
        start_block(40, 0);
        finish_block("l40_stall", 40, 1);
        stall_mode = 0;
        begin
            int diff;
            diff = (cap_q.size() == ref_q.size()) ? 0 : 1;
            for (int i = 0; i < cap_q.size() && i < ref_q.size(); i++)
                if (cap_q[i] !== ref_q[i]) diff++;
            check_eq("l40_stall_vs_clean", diff, 0);
        end

        start_block(40, 0);
        for (int i = 0; i < 2000 && xfer_cnt < 50; i++) @(negedge clk);
        check_eq("rst_mid_reached", xfer_cnt >= 50, 1);
        reset = 1;
        #1;
        check_eq("rst_mid_busy", bus.busy, 0);
        check_eq("rst_mid_valid", bus.d_valid, 0);
        @(negedge clk);
        meta_q.delete();
        data_q.delete();
        pop_m = 0;
        pop_d = 0;
        reset = 0;
        repeat (2) @(negedge clk);

        blk_bytes.delete(); blk_bytes.push_back(8'h80);
        start_block(1, 0);
        finish_block("post_rst", 1, 0);
        check_eq("post_rst_s0", stream_word(0), 16'h00B6);
        check_eq("post_rst_s1", stream_word(1), 16'h00F2);
        check_eq("post_rst_s2", stream_word(2), 16'h00EA);

`ifdef CONV_ENC_TERM_EN
        blk_bytes.delete(); blk_bytes.push_back(8'h80);
        start_block(1, 1);
        finish_block("term", 1, 0);
        check_eq("term_sets14", xfer_cnt, 14);
        check_eq("term_s0", stream_word(0), 16'b0010110110000000);
        bus.term_mode = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
